// File: rtl/cdc_fifo_writer.sv
// cdc_fifo_writer: write-side transmitter for the async CDC FIFO.
// Tags each accepted source word with SOF/EOF flags and feeds it through a
// two-entry (out + skid) buffer into the FIFO write port. Because of the skid
// entry, s_ready comes straight from a register.
// Word format: wdata[DSIZE-1]=SOF, wdata[DSIZE-2]=EOF, wdata[PWIDTH-1:0]=payload.
// DSIZE must equal PWIDTH+2.
//
// Ports:
//   wclk      in   write-domain clock, rising edge
//   rrst      in   synchronous active-high reset
//   s_data    in   source payload            [PWIDTH]
//   s_valid   in   source word valid
//   s_last    in   last word of frame (qualified by s_valid)
//   s_ready   out  block accepts a word this cycle (registered)
//   wdata     out  FIFO write data           [DSIZE]
//   winc      out  FIFO write strobe (out_valid & ~wfull)
//   wfull     in   FIFO full, registered at the FIFO
//   frame_cnt out  frames whose EOF word was pushed, wraps    [CNT_W]
//   stall_cnt out  cycles a pending word was blocked, saturates [CNT_W]
//   busy      out  frame open or any word buffered (registered)
module cdc_fifo_writer #(
    parameter int unsigned DSIZE  = 34,
    parameter int unsigned PWIDTH = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              wclk,
    input  logic              rrst,
    input  logic [PWIDTH-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic [DSIZE-1:0]  wdata,
    output logic              winc,
    input  logic              wfull,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic              busy
);

    typedef enum logic {IDLE, FRAME} state_t;

    state_t             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [DSIZE-1:0]   out_data_q, out_data_d;
    logic               skid_valid_q, skid_valid_d;
    logic [DSIZE-1:0]   skid_data_q, skid_data_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               busy_q, busy_d;
    logic               s_ready_q, s_ready_d;

    logic               accept;
    logic               push;
    logic [DSIZE-1:0]   in_word;

    // State and buffer registers
    always_ff @(posedge wclk) begin
        if (rrst) begin
            state_q      <= IDLE;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            frame_cnt_q  <= '0;
            stall_cnt_q  <= '0;
            busy_q       <= 1'b0;
            s_ready_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            frame_cnt_q  <= frame_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            busy_q       <= busy_d;
            s_ready_q    <= s_ready_d;
        end
    end

    // Next-state, buffer steering and counters
    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        frame_cnt_d  = frame_cnt_q;
        stall_cnt_d  = stall_cnt_q;

        accept  = s_valid & s_ready_q;
        push    = out_valid_q & ~wfull;
        in_word = {(state_q == IDLE), s_last, s_data};

        // Frame tracking advances only on accepted words
        if (accept) begin
            state_d = s_last ? IDLE : FRAME;
        end

        if (!out_valid_q || push) begin
            // Out register is free this cycle; skid (older) goes first
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = accept;
                if (accept) begin
                    skid_data_d = in_word;
                end
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_data_d = in_word;
                end
            end
        end else if (accept) begin
            // Out is held by wfull; park the new word in the skid entry
            skid_valid_d = 1'b1;
            skid_data_d  = in_word;
        end

        if (push && out_data_q[DSIZE-2]) begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end

        if (out_valid_q && wfull && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        // Registered forms of busy and s_ready derived from next-cycle state
        busy_d    = (state_d == FRAME) | out_valid_d | skid_valid_d;
        s_ready_d = ~skid_valid_d;
    end

    // out_data is left untouched when out empties, so wdata holds its last value
    assign wdata     = out_data_q;
    assign winc      = push;
    assign s_ready   = s_ready_q;
    assign frame_cnt = frame_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign busy      = busy_q;

endmodule
